// File: rtl/weight_tile_fifo_pkg.sv
// Shared defaults and element types for the weight tile FIFO.
package weight_fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_LANES  = 32;
    localparam int DEFAULT_DEPTH  = 128;

    typedef logic [DEFAULT_DATA_W-1:0] weight_t;
    typedef weight_t [DEFAULT_LANES-1:0] weight_row_t;

endpackage

// File: rtl/weight_tile_fifo_if.sv
// Loader/consumer bundle of the weight tile FIFO; the FIFO is the slave side.
interface weight_tile_fifo_if
    import weight_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LANES  = DEFAULT_LANES,
    parameter int DEPTH  = DEFAULT_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    // loader side
    logic                    write_en_i;
    logic                    sending_data_i;
    logic [LANES*DATA_W-1:0] data_i;
    logic                    request_data_o;
    // consumer side
    logic                    read_en_i;
    logic                    keep_tile_i;
    logic                    valid_o;
    logic [LANES*DATA_W-1:0] data_o;
    logic                    tile_last_o;
    // status
    logic [CW-1:0]           count_o;
    logic                    empty_o;
    logic                    full_o;
    logic                    almost_full_o;
    logic                    overflow_o;

    modport slave (
        input  write_en_i, sending_data_i, data_i, read_en_i, keep_tile_i,
        output request_data_o, valid_o, data_o, tile_last_o,
               count_o, empty_o, full_o, almost_full_o, overflow_o
    );

    modport master (
        output write_en_i, sending_data_i, data_i, read_en_i, keep_tile_i,
        input  request_data_o, valid_o, data_o, tile_last_o,
               count_o, empty_o, full_o, almost_full_o, overflow_o
    );

endinterface

// File: rtl/weight_tile_fifo_ram.sv
// Simple dual-port row store with a registered, enabled read port (BRAM style).
module weight_fifo_ram
    import weight_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_LANES * DEFAULT_DATA_W,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array is never reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Output register only updates on a read, so the last row is held otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_tile_fifo.sv
// Circular weight row buffer with tile framing and replay; rows retire a tile at a time.
module weight_tile_fifo
    import weight_fifo_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int LANES     = DEFAULT_LANES,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    weight_tile_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(LANES);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] LANES_C = CW'(LANES);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [OW-1:0] LAST_C  = OW'(LANES - 1);
    localparam logic [PW-1:0] STEP_C  = PW'(LANES);

    logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0] tile_base_q, tile_base_d;
    logic [OW-1:0] rd_off_q,    rd_off_d;
    logic [CW-1:0] count_q,     count_d;
    logic          valid_q,     valid_d;
    logic          tile_last_q, tile_last_d;
    logic          overflow_q,  overflow_d;

    logic [CW-1:0] readable;
    logic          empty, full, almost_full;
    logic          wr_try, wr_fire, rd_fire, rd_last, retire;
    logic [PW-1:0] rd_addr;

    // Flags come from registered state only; rd_off counts rows of the tile already read.
    always_comb begin
        readable   = count_q - CW'(rd_off_q);
        empty      = (readable == '0);
        full       = (count_q == DEPTH_C);
        almost_full = (count_q >= AF_C);
        wr_try     = bus.write_en_i & bus.sending_data_i;
        wr_fire    = wr_try & ~full;
        rd_fire    = bus.read_en_i & ~empty;
        rd_last    = (rd_off_q == LAST_C);
        retire     = rd_fire & rd_last & ~bus.keep_tile_i;
        rd_addr    = tile_base_q + PW'(rd_off_q);
    end

    // Next-state for pointers, occupancy and the read-side qualifiers.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        tile_base_d = tile_base_q;
        rd_off_d    = rd_off_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (wr_try & full);
        valid_d     = rd_fire;
        tile_last_d = rd_fire & rd_last;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_off_d = rd_last ? '0 : rd_off_q + 1'b1;
        end
        if (retire) begin
            tile_base_d = tile_base_q + STEP_C;
        end
        count_d = count_q + CW'(wr_fire) - (retire ? LANES_C : '0);
    end

    // Control state registers; reset discards all rows and any replay in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            tile_base_q <= '0;
            rd_off_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            tile_last_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            tile_base_q <= tile_base_d;
            rd_off_q    <= rd_off_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            tile_last_q <= tile_last_d;
            overflow_q  <= overflow_d;
        end
    end

    weight_fifo_ram #(
        .WIDTH (LANES * DATA_W),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (wr_fire),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_i),
        .re_i    (rd_fire),
        .raddr_i (rd_addr),
        .rdata_o (bus.data_o)
    );

    assign bus.request_data_o = bus.write_en_i & ~almost_full;
    assign bus.valid_o        = valid_q;
    assign bus.tile_last_o    = tile_last_q;
    assign bus.count_o        = count_q;
    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.almost_full_o  = almost_full;
    assign bus.overflow_o     = overflow_q;

endmodule
